// File: rtl/riskow_bus_pkg.sv
// Shared types and constants for the Riskow CPU to Wishbone bridge.
package riskow_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  // Number of byte lanes for a given data width.
  function automatic int unsigned sel_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Load/clear/enable down-counter; expired is registered and high once the count reaches zero.
module bus_timeout_counter #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  // Clear beats load beats enable; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      expired <= 1'b0;
    end else if (load) begin
      count_q <= load_value;
      expired <= (load_value == '0);
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
      expired <= (count_q == WIDTH'(1));
    end
  end

endmodule

// File: rtl/riskow_wb_bridge.sv
// Riskow CPU valid/ready port to Wishbone classic bridge with timeout, sticky error and txn counter.
module riskow_wb_bridge
  import riskow_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(DEFAULT_ERR_DATA)
) (
  input  logic                             sys_clk,
  input  logic                             rst_n,
  input  logic                             cpu_valid_i,
  input  logic                             cpu_we_i,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]            cpu_wdata_i,
  output logic [DATA_WIDTH-1:0]            cpu_rdata_o,
  output logic                             cpu_ready_o,
  output logic                             wb_cyc_o,
  output logic                             wb_stb_o,
  output logic                             wb_we_o,
  output logic [ADDR_WIDTH-1:0]            wb_addr_o,
  output logic [DATA_WIDTH-1:0]            wb_data_o,
  output logic [sel_width(DATA_WIDTH)-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]            wb_data_i,
  input  logic                             wb_ack_i,
  output logic                             bus_err_o,
  output logic [31:0]                      txn_count_o
);

  localparam int unsigned SEL_W   = sel_width(DATA_WIDTH);
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TO_LOAD = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  bridge_state_t          state_q, state_d;
  logic                   cyc_d, we_d, ready_d, err_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [DATA_WIDTH-1:0]  wdata_d, rdata_d;
  logic [SEL_W-1:0]       sel_d;
  logic [31:0]            txn_d;
  logic                   tmr_clear, tmr_load, tmr_enable, tmr_expired, timeout_hit;

  // Cycle and strobe are one register, so they can never disagree.
  assign wb_stb_o    = wb_cyc_o;
  assign timeout_hit = TO_EN && tmr_expired;

  bus_timeout_counter #(
    .WIDTH(TO_W)
  ) u_timeout (
    .clk       (sys_clk),
    .rst_n     (rst_n),
    .clear     (tmr_clear),
    .load      (tmr_load),
    .enable    (tmr_enable),
    .load_value(TO_W'(TO_LOAD)),
    .expired   (tmr_expired)
  );

  // State and all output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_cyc_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_sel_o    <= '0;
      cpu_rdata_o <= '0;
      cpu_ready_o <= 1'b0;
      bus_err_o   <= 1'b0;
      txn_count_o <= '0;
    end else begin
      state_q     <= state_d;
      wb_cyc_o    <= cyc_d;
      wb_we_o     <= we_d;
      wb_addr_o   <= addr_d;
      wb_data_o   <= wdata_d;
      wb_sel_o    <= sel_d;
      cpu_rdata_o <= rdata_d;
      cpu_ready_o <= ready_d;
      bus_err_o   <= err_d;
      txn_count_o <= txn_d;
    end
  end

  // Next-state and next-output logic; ack outside REQ is deliberately ignored.
  always_comb begin
    state_d    = state_q;
    cyc_d      = wb_cyc_o;
    we_d       = wb_we_o;
    addr_d     = wb_addr_o;
    wdata_d    = wb_data_o;
    sel_d      = wb_sel_o;
    rdata_d    = cpu_rdata_o;
    ready_d    = 1'b0;
    err_d      = bus_err_o;
    txn_d      = txn_count_o;
    tmr_clear  = 1'b0;
    tmr_load   = 1'b0;
    tmr_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_valid_i) begin
          addr_d   = cpu_addr_i;
          wdata_d  = cpu_wdata_i;
          we_d     = cpu_we_i;
          cyc_d    = 1'b1;
          sel_d    = '1;
          tmr_load = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        tmr_enable = 1'b1;
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          sel_d   = '0;
          ready_d = 1'b1;
          if (!wb_we_o) rdata_d = wb_data_i;
          state_d = RESP;
        end else if (timeout_hit) begin
          cyc_d   = 1'b0;
          sel_d   = '0;
          ready_d = 1'b1;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        txn_d     = txn_count_o + 32'd1;
        tmr_clear = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_riskow_wb_bridge.sv
// Directed self-checking bench for riskow_wb_bridge (TIMEOUT_CYCLES = 8).
module tb_riskow_wb_bridge;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_ready_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, bus_err_o;
  logic [31:0] txn_count_o;

  int checks = 0;
  int fails  = 0;

  always #5 sys_clk = ~sys_clk;

  riskow_wb_bridge #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .cpu_valid_i(cpu_valid_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o),
    .cpu_ready_o(cpu_ready_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_sel_o   (wb_sel_o),
    .wb_data_i  (wb_data_i),
    .wb_ack_i   (wb_ack_i),
    .bus_err_o  (bus_err_o),
    .txn_count_o(txn_count_o)
  );

  task automatic test_reset();
    rst_n = 1'b0; cpu_valid_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    wb_data_i = '0; wb_ack_i = 1'b0;
    repeat (2) @(negedge sys_clk);
    checks++; if ({wb_cyc_o, wb_stb_o, cpu_ready_o, wb_we_o, bus_err_o} !== 5'b0) begin fails++; $display("FAIL reset_ctrl: got %b want 00000", {wb_cyc_o, wb_stb_o, cpu_ready_o, wb_we_o, bus_err_o}); end
    checks++; if ({cpu_rdata_o, wb_addr_o, wb_data_o, txn_count_o} !== 128'd0) begin fails++; $display("FAIL reset_data: rdata=%h addr=%h data=%h txn=%0d want 0", cpu_rdata_o, wb_addr_o, wb_data_o, txn_count_o); end
    checks++; if (wb_sel_o !== 4'h0) begin fails++; $display("FAIL reset_sel: got %h want 0", wb_sel_o); end
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_read_zero_wait();
    cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    @(negedge sys_clk);
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b110_1111) begin fails++; $display("FAIL rd_req: cyc/stb/we/sel got %b want 1101111", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
    checks++; if (wb_addr_o !== 32'h100) begin fails++; $display("FAIL rd_addr: got %h want 00000100", wb_addr_o); end
    cpu_valid_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h1234_5678;
    @(negedge sys_clk);
    wb_ack_i = 1'b0; wb_data_i = 32'h0;
    checks++; if ({cpu_ready_o, wb_stb_o} !== 2'b10) begin fails++; $display("FAIL rd_ready: ready/stb got %b want 10", {cpu_ready_o, wb_stb_o}); end
    checks++; if (cpu_rdata_o !== 32'h1234_5678) begin fails++; $display("FAIL rd_data: got %h want 12345678", cpu_rdata_o); end
    @(negedge sys_clk);
    checks++; if (cpu_ready_o !== 1'b0) begin fails++; $display("FAIL rd_pulse: ready got %b want 0", cpu_ready_o); end
    checks++; if (txn_count_o !== 32'd1) begin fails++; $display("FAIL rd_txn: got %0d want 1", txn_count_o); end
  endtask

  task automatic test_write_wait();
    cpu_valid_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h200; cpu_wdata_i = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sys_clk);
      checks++; if ({wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o} !== {1'b1, 1'b1, 4'hF, 32'h200, 32'hCAFE_F00D})
        begin fails++; $display("FAIL wr_hold%0d: stb=%b we=%b sel=%h addr=%h data=%h want 1 1 f 00000200 cafef00d", k, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o); end
      if (k == 1) begin cpu_valid_i = 1'b0; cpu_addr_i = 32'hFFFF_0000; cpu_wdata_i = 32'h0BAD_0BAD; cpu_we_i = 1'b0; end
      if (k == 4) begin wb_ack_i = 1'b1; wb_data_i = 32'h7777_7777; end
    end
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    checks++; if ({cpu_ready_o, wb_stb_o} !== 2'b10) begin fails++; $display("FAIL wr_ready: ready/stb got %b want 10", {cpu_ready_o, wb_stb_o}); end
    checks++; if (cpu_rdata_o !== 32'h1234_5678) begin fails++; $display("FAIL wr_rdata: got %h want 12345678", cpu_rdata_o); end
    @(negedge sys_clk);
    checks++; if (txn_count_o !== 32'd2) begin fails++; $display("FAIL wr_txn: got %0d want 2", txn_count_o); end
  endtask

  task automatic test_ack_on_expiry();
    int n = 0;
    cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h400;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (wb_stb_o) n++;
      if (n == 1) cpu_valid_i = 1'b0;
      if (n == 8) begin wb_ack_i = 1'b1; wb_data_i = 32'h5; break; end
    end
    checks++; if (n !== 8) begin fails++; $display("FAIL exp_stb_cycles: got %0d want 8", n); end
    @(negedge sys_clk);
    wb_ack_i = 1'b0; wb_data_i = 32'h0;
    checks++; if ({cpu_ready_o, wb_stb_o, bus_err_o} !== 3'b100) begin fails++; $display("FAIL exp_ready: ready/stb/err got %b want 100", {cpu_ready_o, wb_stb_o, bus_err_o}); end
    checks++; if (cpu_rdata_o !== 32'h5) begin fails++; $display("FAIL exp_rdata: got %h want 00000005", cpu_rdata_o); end
    @(negedge sys_clk);
    checks++; if (txn_count_o !== 32'd3) begin fails++; $display("FAIL exp_txn: got %0d want 3", txn_count_o); end
  endtask

  task automatic test_timeout();
    int n = 0, last_stb = -1, ready_at = -1;
    cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      cpu_valid_i = 1'b0;
      if (wb_stb_o) begin n++; last_stb = i; end
      if (cpu_ready_o) begin ready_at = i; break; end
    end
    checks++; if (n !== 8) begin fails++; $display("FAIL to_stb_cycles: got %0d want 8", n); end
    checks++; if (ready_at !== last_stb + 1) begin fails++; $display("FAIL to_ready_time: ready at %0d want %0d", ready_at, last_stb + 1); end
    checks++; if (cpu_rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL to_rdata: got %h want deadbeef", cpu_rdata_o); end
    checks++; if (bus_err_o !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", bus_err_o); end
    @(negedge sys_clk);
    checks++; if (txn_count_o !== 32'd4) begin fails++; $display("FAIL to_txn: got %0d want 4", txn_count_o); end
  endtask

  task automatic test_back_to_back();
    int rise[3];
    int nrise = 0, nready = 0, nstb = 0;
    logic prev_stb = 1'b0;
    cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h500;
    wb_ack_i = 1'b1; wb_data_i = 32'hA0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge sys_clk);
      if (wb_stb_o) nstb++;
      if (wb_stb_o && !prev_stb) begin
        if (nrise < 3) rise[nrise] = c;
        nrise++;
      end
      prev_stb = wb_stb_o;
      if (cpu_ready_o) nready++;
      wb_data_i = 32'hA0 + 32'(c);
      if (c == 7) cpu_valid_i = 1'b0;
    end
    wb_ack_i = 1'b0;
    checks++; if (nrise !== 3 || nstb !== 3) begin fails++; $display("FAIL b2b_bursts: bursts=%0d stb_cycles=%0d want 3 3", nrise, nstb); end
    checks++; if (nrise >= 3 && (rise[1] - rise[0] !== 3 || rise[2] - rise[1] !== 3)) begin fails++; $display("FAIL b2b_interval: rises %0d %0d %0d want spacing 3", rise[0], rise[1], rise[2]); end
    checks++; if (nready !== 3) begin fails++; $display("FAIL b2b_ready: got %0d pulses want 3", nready); end
    checks++; if (cpu_rdata_o !== 32'hA7) begin fails++; $display("FAIL b2b_rdata: got %h want 000000a7", cpu_rdata_o); end
    checks++; if (txn_count_o !== 32'd7) begin fails++; $display("FAIL b2b_txn: got %0d want 7", txn_count_o); end
    checks++; if (bus_err_o !== 1'b1) begin fails++; $display("FAIL b2b_err_sticky: got %b want 1", bus_err_o); end
  endtask

  task automatic test_reset_mid_req();
    cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h600;
    @(negedge sys_clk);
    cpu_valid_i = 1'b0;
    @(negedge sys_clk);
    checks++; if (wb_stb_o !== 1'b1) begin fails++; $display("FAIL rst_pre_stb: got %b want 1", wb_stb_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({wb_cyc_o, wb_stb_o, cpu_ready_o, bus_err_o} !== 4'b0) begin fails++; $display("FAIL rst_async: cyc/stb/ready/err got %b want 0000", {wb_cyc_o, wb_stb_o, cpu_ready_o, bus_err_o}); end
    checks++; if (txn_count_o !== 32'd0 || cpu_rdata_o !== 32'd0) begin fails++; $display("FAIL rst_counters: txn=%0d rdata=%h want 0 0", txn_count_o, cpu_rdata_o); end
    @(negedge sys_clk);
    rst_n = 1'b1;
    wb_ack_i = 1'b1; wb_data_i = 32'h9999_9999;
    repeat (2) begin
      @(negedge sys_clk);
      checks++; if ({cpu_ready_o, wb_stb_o} !== 2'b00 || cpu_rdata_o !== 32'd0 || txn_count_o !== 32'd0)
        begin fails++; $display("FAIL rst_late_ack: ready/stb=%b rdata=%h txn=%0d want 00 0 0", {cpu_ready_o, wb_stb_o}, cpu_rdata_o, txn_count_o); end
    end
    wb_ack_i = 1'b0;
    cpu_valid_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h700; cpu_wdata_i = 32'h1111_2222;
    @(negedge sys_clk);
    cpu_valid_i = 1'b0;
    checks++; if ({wb_stb_o, wb_we_o, wb_addr_o, wb_data_o} !== {1'b1, 1'b1, 32'h700, 32'h1111_2222}) begin fails++; $display("FAIL post_rst_req: stb=%b we=%b addr=%h data=%h want 1 1 00000700 11112222", wb_stb_o, wb_we_o, wb_addr_o, wb_data_o); end
    wb_ack_i = 1'b1;
    @(negedge sys_clk);
    wb_ack_i = 1'b0;
    checks++; if (cpu_ready_o !== 1'b1 || bus_err_o !== 1'b0) begin fails++; $display("FAIL post_rst_ready: ready=%b err=%b want 1 0", cpu_ready_o, bus_err_o); end
    @(negedge sys_clk);
    checks++; if (txn_count_o !== 32'd1) begin fails++; $display("FAIL post_rst_txn: got %0d want 1", txn_count_o); end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_ack_on_expiry();
    test_timeout();
    test_back_to_back();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
